// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the fetch-stage instruction requester and
//   the mem-stage data requester. Data is the older instruction, so it always
//   wins when both are pending. A grant is never preempted. Results are held
//   while the other requester is still outstanding. One global stall freezes
//   the pipeline until every active request of the current pipeline cycle has
//   been served.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access in flight; decide which requester to grant
//   DATA  | data access on the port, waiting for mem_ack
//   INST  | instruction fetch on the port, waiting for mem_ack
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/inst_addr       fetch request, address stable while stall=1
//   inst_rdata               instruction word (bypassed on the ack cycle)
//   data_req/we/be/addr/wdata mem-stage load/store request
//   data_rdata               load data (bypassed on the ack cycle)
//   stall                    combinational pipeline freeze
//   mem_req/we/be/addr/wdata registered memory request, held until mem_ack
//   mem_rdata/mem_ack        memory response
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [DW/8-1:0] data_be,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t          state;
  logic            instDone;
  logic            dataDone;
  logic [DW-1:0]   instRdataQ;
  logic [DW-1:0]   dataRdataQ;
  logic            memReqQ;
  logic            memWeQ;
  logic [DW/8-1:0] memBeQ;
  logic [AW-1:0]   memAddrQ;
  logic [DW-1:0]   memWdataQ;

  logic dPend;
  logic iPend;
  logic ackedData;
  logic ackedInst;

  assign dPend     = data_req & ~dataDone;
  assign iPend     = inst_req & ~instDone;
  assign ackedData = (state == DATA) & mem_ack;
  assign ackedInst = (state == INST) & mem_ack;

  // A request acked this cycle no longer holds the pipeline.
  assign stall = (dPend & ~ackedData) | (iPend & ~ackedInst);

  assign inst_rdata = ackedInst ? mem_rdata : instRdataQ;
  assign data_rdata = ackedData ? mem_rdata : dataRdataQ;

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_be    = memBeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instDone   <= 1'b0;
      dataDone   <= 1'b0;
      instRdataQ <= '0;
      dataRdataQ <= '0;
      memReqQ    <= 1'b0;
      memWeQ     <= 1'b0;
      memBeQ     <= '0;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
    end else begin
      // Pipeline advance (stall=0) starts a fresh cycle: forget everything,
      // including an ack landing in that same cycle.
      instDone <= stall ? (instDone | ackedInst) : 1'b0;
      dataDone <= stall ? (dataDone | ackedData) : 1'b0;

      unique case (state)
        IDLE: begin
          if (dPend) begin
            state     <= DATA;
            memReqQ   <= 1'b1;
            memWeQ    <= data_we;
            memBeQ    <= data_be;
            memAddrQ  <= data_addr;
            memWdataQ <= data_wdata;
          end else if (iPend) begin
            state    <= INST;
            memReqQ  <= 1'b1;
            memWeQ   <= 1'b0;
            memBeQ   <= '1;
            memAddrQ <= inst_addr;
          end
        end
        DATA: begin
          if (mem_ack) begin
            dataRdataQ <= mem_rdata;
            if (iPend) begin
              state    <= INST;
              memWeQ   <= 1'b0;
              memBeQ   <= '1;
              memAddrQ <= inst_addr;
            end else begin
              state   <= IDLE;
              memReqQ <= 1'b0;
            end
          end
        end
        INST: begin
          if (mem_ack) begin
            instRdataQ <= mem_rdata;
            if (dPend) begin
              state     <= DATA;
              memWeQ    <= data_we;
              memBeQ    <= data_be;
              memAddrQ  <= data_addr;
              memWdataQ <= data_wdata;
            end else begin
              state   <= IDLE;
              memReqQ <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          memReqQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;
  logic        mem_ack = 1'b0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit          memReq;
    bit          chkI;
    logic [31:0] instR;
    bit          chkD;
    logic [31:0] dataR;
    bit          chkZero;
  } cycExp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
  } resp_t;

  cycExp_t cycQ[$];
  acc_t    accQ[$];
  resp_t   respQ[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks the head response after its wait count.
  int waitCnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_ack) begin
      void'(respQ.pop_front());
      waitCnt = 0;
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    if (!mem_req) begin
      waitCnt = 0;
    end else if (respQ.size() > 0) begin
      if (waitCnt == respQ[0].waits) begin
        mem_ack   = 1'b1;
        mem_rdata = respQ[0].rdata;
      end else begin
        waitCnt++;
      end
    end
  end

  // Monitor: per-cycle expectations plus ordered memory-access scoreboard.
  cycExp_t ce;
  acc_t    aa;
  acc_t    ea;
  always @(negedge clk) begin
    if (cycQ.size() > 0) begin
      ce = cycQ.pop_front();
      check("stall", 96'(stall), 96'(ce.stall));
      check("mem_req", 96'(mem_req), 96'(ce.memReq));
      if (ce.chkI) check("inst_rdata", 96'(inst_rdata), 96'(ce.instR));
      if (ce.chkD) check("data_rdata", 96'(data_rdata), 96'(ce.dataR));
      if (ce.chkZero)
        check("mem_regs_reset", 96'({mem_addr, mem_we, mem_be, mem_wdata}), 96'(0));
    end
    if (mem_req === 1'b1) begin
      if (accQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: got addr %h we %b, expected no access", mem_addr, mem_we);
      end else begin
        ea = accQ[0];
        if (!ea.we) ea.wdata = 32'h0;
        aa = {mem_addr, mem_we, mem_be, (mem_we ? mem_wdata : 32'h0)};
        check("mem_access", 96'(aa), 96'(ea));
        if (mem_ack) void'(accQ.pop_front());
      end
    end
  end

  task automatic cyc(input bit s, input bit r,
                     input bit ci = 1'b0, input logic [31:0] ei = 32'h0,
                     input bit cd = 1'b0, input logic [31:0] ed = 32'h0,
                     input bit cz = 1'b0);
    cycExp_t e;
    e.stall = s; e.memReq = r; e.chkI = ci; e.instR = ei;
    e.chkD = cd; e.dataR = ed; e.chkZero = cz;
    cycQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pushAcc(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    acc_t x;
    x.addr = a; x.we = w; x.be = b; x.wdata = d;
    accQ.push_back(x);
  endtask

  task automatic pushResp(input logic [31:0] d, input int w);
    resp_t x;
    x.rdata = d; x.waits = w;
    respQ.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 1, 32'h0, 1, 32'h0, 1);
    rst = 1'b0;

    // single fetch, zero-wait memory
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    pushAcc(32'h0040_0000, 1'b0, 4'hF, 32'h0); pushResp(32'h2408_0005, 0);
    cyc(1, 0);
    cyc(0, 1, 1, 32'h2408_0005);
    inst_req = 1'b0;
    cyc(0, 0, 1, 32'h2408_0005);

    // simultaneous load and fetch: data first, then inst
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h1001_0000;
    inst_req = 1'b1; inst_addr = 32'h0040_0004;
    pushAcc(32'h1001_0000, 1'b0, 4'hF, 32'h0); pushAcc(32'h0040_0004, 1'b0, 4'hF, 32'h0);
    pushResp(32'hDEAD_BEEF, 0); pushResp(32'h8C09_0000, 0);
    cyc(1, 0);
    cyc(1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    cyc(0, 1, 1, 32'h8C09_0000, 1, 32'hDEAD_BEEF);
    data_req = 1'b0; inst_req = 1'b0;
    cyc(0, 0, 1, 32'h8C09_0000, 1, 32'hDEAD_BEEF);

    // store with three wait cycles
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h1001_0004; data_wdata = 32'h0000_ABCD;
    pushAcc(32'h1001_0004, 1'b1, 4'b0011, 32'h0000_ABCD); pushResp(32'h1111_2222, 3);
    cyc(1, 0);
    repeat (3) cyc(1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 32'h0, 1, 32'h1111_2222);
    data_req = 1'b0; data_we = 1'b0;
    cyc(0, 0, 0, 32'h0, 1, 32'h1111_2222);

    // data arrives while fetch in flight: no preemption, no fetch reissue
    inst_req = 1'b1; inst_addr = 32'h0040_0008;
    pushAcc(32'h0040_0008, 1'b0, 4'hF, 32'h0); pushAcc(32'h1001_0008, 1'b0, 4'hF, 32'h0);
    pushResp(32'h0123_4567, 0); pushResp(32'h89AB_CDEF, 0);
    cyc(1, 0);
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h1001_0008;
    cyc(1, 1, 1, 32'h0123_4567);
    cyc(0, 1, 1, 32'h0123_4567, 1, 32'h89AB_CDEF);
    data_req = 1'b0; inst_req = 1'b0;
    cyc(0, 0, 1, 32'h0123_4567, 1, 32'h89AB_CDEF);

    // reset during a stalled store; store must not be reissued
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
    data_addr = 32'h1001_0010; data_wdata = 32'h0000_0055;
    pushAcc(32'h1001_0010, 1'b1, 4'hF, 32'h0000_0055); pushResp(32'h0, 10);
    cyc(1, 0);
    cyc(1, 1);
    rst = 1'b1;
    cyc(1, 1);
    rst = 1'b0; data_req = 1'b0; data_we = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0040_0010;
    accQ.delete(); respQ.delete();
    pushAcc(32'h0040_0010, 1'b0, 4'hF, 32'h0); pushResp(32'hCAFE_0001, 0);
    cyc(1, 0, 1, 32'h0, 1, 32'h0, 1);
    cyc(0, 1, 1, 32'hCAFE_0001);
    inst_req = 1'b0;
    cyc(0, 0, 1, 32'hCAFE_0001);

    // four back-to-back fetches across pipeline advances
    inst_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'(i * 4);
      pushAcc(32'(i * 4), 1'b0, 4'hF, 32'h0); pushResp(32'(32'h1000 + i), 0);
      cyc(1, 0);
      cyc(0, 1, 1, 32'(32'h1000 + i));
    end
    inst_req = 1'b0;
    cyc(0, 0, 1, 32'h0000_1003);

    @(negedge clk);
    #1;
    check("acc_queue_drained", 96'(accQ.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
